print_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single `printer` string engine between several requesters: the start banner state, command responses and error reporting. It sits between the requester state machines in `top` and the `printer` instance. It grants one requester at a time, drives `printer_str_id`/`printer_enable` for the whole print, and returns a one-cycle completion pulse to the owner.

---
 rtl/print_arbiter_if.sv | 36 +++
 rtl/print_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_print_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/print_arbiter_if.sv
// print_arbiter_if: bundle of the request/grant handshake and the printer
// control lines shared between the requesters, the printer and print_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever drives the requests and the printer completion.
interface print_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int STR_ID_W = 2
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*STR_ID_W-1:0] req_str_id;
  logic [NUM_REQ-1:0]          req_grant;
  logic [NUM_REQ-1:0]          req_done;
  logic [STR_ID_W-1:0]         printer_str_id;
  logic                        printer_enable;
  logic                        printer_done;

  modport slave (
    input  req_valid,
    input  req_str_id,
    input  printer_done,
    output req_grant,
    output req_done,
    output printer_str_id,
    output printer_enable
  );

  modport master (
    output req_valid,
    output req_str_id,
    output printer_done,
    input  req_grant,
    input  req_done,
    input  printer_str_id,
    input  printer_enable
  );
endinterface

// File: rtl/print_arbiter.sv
// print_arbiter: round-robin owner of the shared printer string engine.
// One requester is granted at a time. Its string id is latched and the printer
// is enabled until printer_done. The owner then gets a one-cycle req_done and
// the arbiter waits for printer_done to fall before arbitrating again, so both
// pulse-style and level-style done signals are handled.
//
// Optional feature: define PRINT_ARB_TIMEOUT_EN to add a RUN watchdog of
// TIMEOUT_CYCLES clocks. On expiry the print is ended as if done had arrived,
// and the sticky timeout_err flag is raised. Without the macro, RUN waits
// forever and timeout_err is constant 0.
module print_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int STR_ID_W       = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  print_arbiter_if.slave    bus,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  grant_next;
  logic [NUM_REQ-1:0]  done_q;
  logic [NUM_REQ-1:0]  done_next;
  logic [STR_ID_W-1:0] str_id_q;
  logic [STR_ID_W-1:0] str_id_next;
  logic                enable_q;
  logic                enable_next;
  logic                busy_q;
  logic                busy_next;
  logic [IDX_W-1:0]    last_ptr;
  logic [IDX_W-1:0]    last_ptr_next;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand;
  logic [STR_ID_W-1:0] pick_str_id;
  logic                run_entry;
  logic                expired;

  // Rotating-priority search: the requester after the previous owner is
  // looked at first, so the previous owner is looked at last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_ptr) + k) % NUM_REQ);
      if (!pick_valid && bus.req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_str_id = bus.req_str_id[pick_idx*STR_ID_W +: STR_ID_W];
  assign run_entry   = (state == IDLE) && pick_valid;

  // Next-state and next-output logic. Every output is computed one cycle
  // ahead and registered, so nothing downstream sees combinational paths.
  always_comb begin
    state_next    = state;
    grant_next    = grant_q;
    done_next     = '0;
    str_id_next   = str_id_q;
    enable_next   = enable_q;
    last_ptr_next = last_ptr;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next           = RUN;
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          str_id_next          = pick_str_id;
          enable_next          = 1'b1;
          last_ptr_next        = pick_idx;
        end
      end
      RUN: begin
        if (bus.printer_done || expired) begin
          state_next  = RELEASE;
          enable_next = 1'b0;
          grant_next  = '0;
          done_next   = grant_q;
        end
      end
      RELEASE: begin
        enable_next = 1'b0;
        if (!bus.printer_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        grant_next  = '0;
        enable_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers. Reset clears everything immediately so the
  // printer sees enable fall without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      str_id_q <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      last_ptr <= LAST_RESET;
    end else begin
      state    <= state_next;
      grant_q  <= grant_next;
      done_q   <= done_next;
      str_id_q <= str_id_next;
      enable_q <= enable_next;
      busy_q   <= busy_next;
      last_ptr <= last_ptr_next;
    end
  end

`ifdef PRINT_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] run_cnt;
  logic             timeout_q;

  // Count completed RUN cycles. The count restarts on every grant and stops
  // at the last value, where the expiry condition below takes over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (run_entry) begin
      run_cnt <= '0;
    end else if ((state == RUN) && (run_cnt != CNT_LAST)) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  assign expired = (state == RUN) && (run_cnt == CNT_LAST);

  // Sticky error flag. A done arriving in the expiry cycle wins and is
  // treated as an ordinary completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (expired && !bus.printer_done) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout;

  assign expired        = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES[0] ^ run_entry;
`endif

  assign bus.req_grant      = grant_q;
  assign bus.req_done       = done_q;
  assign bus.printer_str_id = str_id_q;
  assign bus.printer_enable = enable_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_print_arbiter.sv
// tb_print_arbiter: directed test of print_arbiter against a queue-free
// behavioural model of the owner / rotation / release rules, plus literal
// expectations at the key points of each scenario.
module tb_print_arbiter;

  localparam int NUM_REQ        = 3;
  localparam int STR_ID_W       = 2;
  localparam int TIMEOUT_CYCLES = 16;
`ifdef PRINT_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  print_arbiter_if #(.NUM_REQ(NUM_REQ), .STR_ID_W(STR_ID_W)) bus ();

  print_arbiter #(
    .NUM_REQ(NUM_REQ),
    .STR_ID_W(STR_ID_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Model: who owns the printer (-1 = nobody), whether we wait for done to
  // fall, who was served last, and how long the current print has run.
  int                  m_owner;
  int                  m_last;
  int                  m_run_len;
  int                  m_c;
  bit                  m_release;
  bit                  m_terr;
  logic [NUM_REQ-1:0]  m_done;
  logic [STR_ID_W-1:0] m_id;
  logic [NUM_REQ-1:0]  e_grant;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner   = -1;
      m_last    = NUM_REQ - 1;
      m_run_len = 0;
      m_release = 1'b0;
      m_terr    = 1'b0;
      m_done    = '0;
      m_id      = '0;
    end else begin
      m_done = '0;
      if (m_owner >= 0) begin
        m_run_len = m_run_len + 1;
        if (bus.printer_done || (TIMEOUT_ON && m_run_len >= TIMEOUT_CYCLES)) begin
          if (!bus.printer_done) m_terr = 1'b1;
          m_done[m_owner] = 1'b1;
          m_owner         = -1;
          m_release       = 1'b1;
        end
      end else if (m_release) begin
        if (!bus.printer_done) m_release = 1'b0;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          m_c = (m_last + k) % NUM_REQ;
          if (bus.req_valid[m_c]) begin
            m_owner   = m_c;
            m_last    = m_c;
            m_id      = bus.req_str_id[m_c*STR_ID_W +: STR_ID_W];
            m_run_len = 0;
            break;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (!rst && model_on) begin
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      checkOutput("model_grant",  32'(bus.req_grant),      32'(e_grant));
      checkOutput("model_done",   32'(bus.req_done),       32'(m_done));
      checkOutput("model_str_id", 32'(bus.printer_str_id), 32'(m_id));
      checkOutput("model_enable", 32'(bus.printer_enable), 32'(m_owner >= 0));
      checkOutput("model_busy",   32'(busy),               32'((m_owner >= 0) || m_release));
      checkOutput("model_terr",   32'(timeout_err),        32'(m_terr));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ*STR_ID_W-1:0] ids);
    bus.req_valid  = valid;
    bus.req_str_id = ids;
  endtask

  task automatic doneDrop();
    bus.printer_done = 1'b1;
    tick();
    bus.printer_done = 1'b0;
  endtask

  task automatic waitGrant(output logic [NUM_REQ-1:0] g, output int low_cycles);
    g          = '0;
    low_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.req_grant != '0) begin
        g = bus.req_grant;
        return;
      end
      if (!bus.printer_enable) low_cycles++;
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL grant_wait: got no grant, expected one within 20 cycles");
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [NUM_REQ-1:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [NUM_REQ-1:0] g;
  int                 low;
  int                 n;

  initial begin
    bus.req_valid    = '0;
    bus.req_str_id   = '0;
    bus.printer_done = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_grant",  32'(bus.req_grant),      32'h0);
    checkOutput("rst_done",   32'(bus.req_done),       32'h0);
    checkOutput("rst_enable", 32'(bus.printer_enable), 32'h0);
    checkOutput("rst_str_id", 32'(bus.printer_str_id), 32'h0);
    checkOutput("rst_busy",   32'(busy),               32'h0);
    checkOutput("rst_terr",   32'(timeout_err),        32'h0);
    tick();
    rst      = 1'b0;
    model_on = 1'b1;

    // Single request from requester 1 with id 2
    $display("[TB] single request");
    applyStimulus(3'b010, 6'b00_10_00);
    tick();
    checkOutput("single_grant",  32'(bus.req_grant),      32'h2);
    checkOutput("single_str_id", 32'(bus.printer_str_id), 32'h2);
    checkOutput("single_enable", 32'(bus.printer_enable), 32'h1);
    checkOutput("single_busy",   32'(busy),               32'h1);
    tick(2);
    checkOutput("single_hold",   32'(bus.req_grant),      32'h2);
    bus.printer_done = 1'b1;
    tick();
    checkOutput("single_done",   32'(bus.req_done),       32'h2);
    checkOutput("single_en_low", 32'(bus.printer_enable), 32'h0);
    checkOutput("single_no_gnt", 32'(bus.req_grant),      32'h0);
    bus.printer_done = 1'b0;
    applyStimulus(3'b000, 6'b00_10_00);
    tick();
    checkOutput("single_done_1", 32'(bus.req_done),       32'h0);
    checkOutput("single_idle",   32'(busy),               32'h0);

    // Contention: all three held, rotation 0,1,2,0 with a 2-cycle enable gap
    $display("[TB] contention");
    doReset();
    applyStimulus(3'b111, 6'b10_01_00);
    for (int i = 0; i < 4; i++) begin
      waitGrant(g, low);
      checkOutput("rr_order", 32'(g), 32'(rr_exp[i]));
      if (i > 0) checkOutput("rr_enable_gap", 32'(low + 1), 32'd2);
      bus.printer_done = 1'b1;
      tick();
      checkOutput("rr_done", 32'(bus.req_done), 32'(rr_exp[i]));
      bus.printer_done = 1'b0;
    end
    applyStimulus(3'b000, 6'b10_01_00);
    tick(3);

    // Id stability: the owner's id changes from 1 to 3 mid-print
    $display("[TB] id stability");
    doReset();
    applyStimulus(3'b001, 6'b00_00_01);
    waitGrant(g, low);
    checkOutput("id_grant", 32'(g), 32'h1);
    applyStimulus(3'b001, 6'b00_00_11);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("id_latched", 32'(bus.printer_str_id), 32'h1);
    end
    bus.printer_done = 1'b1;
    tick();
    checkOutput("id_done", 32'(bus.req_done), 32'h1);
    bus.printer_done = 1'b0;
    applyStimulus(3'b000, 6'b00_00_11);
    tick(2);

    // Level done held 5 cycles: no new grant until it falls
    $display("[TB] level done");
    applyStimulus(3'b010, 6'b01_10_00);
    waitGrant(g, low);
    checkOutput("lvl_grant", 32'(g), 32'h2);
    applyStimulus(3'b110, 6'b01_10_00);
    bus.printer_done = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (j == 0) begin
        checkOutput("lvl_done", 32'(bus.req_done), 32'h2);
        applyStimulus(3'b100, 6'b01_10_00);
      end
      checkOutput("lvl_no_grant", 32'(bus.req_grant), 32'h0);
      checkOutput("lvl_busy",     32'(busy),          32'h1);
    end
    bus.printer_done = 1'b0;
    waitGrant(g, low);
    checkOutput("lvl_next_grant", 32'(g), 32'h4);
    checkOutput("lvl_next_id",    32'(bus.printer_str_id), 32'h1);
    doneDrop();
    applyStimulus(3'b000, 6'b01_10_00);
    tick(2);

    // Reset mid-print, then requester 0 wins first
    $display("[TB] reset mid-print");
    applyStimulus(3'b100, 6'b11_00_00);
    waitGrant(g, low);
    checkOutput("rmp_grant", 32'(g), 32'h4);
    tick(2);
    #2 rst = 1'b1;
    #1;
    checkOutput("rmp_enable", 32'(bus.printer_enable), 32'h0);
    checkOutput("rmp_grant0", 32'(bus.req_grant),      32'h0);
    checkOutput("rmp_busy",   32'(busy),               32'h0);
    checkOutput("rmp_done",   32'(bus.req_done),       32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(3'b111, 6'b11_10_01);
    waitGrant(g, low);
    checkOutput("rmp_first", 32'(g), 32'h1);
    doneDrop();
    applyStimulus(3'b000, 6'b11_10_01);
    tick(3);

    // Watchdog: printer never answers
    $display("[TB] watchdog");
    applyStimulus(3'b001, 6'b00_00_10);
    waitGrant(g, low);
    checkOutput("wd_grant", 32'(g), 32'h1);
`ifdef PRINT_ARB_TIMEOUT_EN
    n = 0;
    while (bus.req_done == '0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("wd_latency", 32'(n),                   32'd16);
    checkOutput("wd_done",    32'(bus.req_done),        32'h1);
    checkOutput("wd_enable",  32'(bus.printer_enable),  32'h0);
    checkOutput("wd_terr",    32'(timeout_err),         32'h1);
    applyStimulus(3'b000, 6'b00_00_10);
    tick(5);
    checkOutput("wd_terr_sticky", 32'(timeout_err), 32'h1);
`else
    n = 0;
    tick(1000);
    checkOutput("wd_still_grant", 32'(bus.req_grant),      32'h1);
    checkOutput("wd_still_en",    32'(bus.printer_enable), 32'h1);
    checkOutput("wd_terr_off",    32'(timeout_err),        32'h0);
    doneDrop();
    applyStimulus(3'b000, 6'b00_00_10);
    tick(3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
